// File: rtl/tetris_pkg.sv
// Shared board geometry, line-clear FSM states, score table and row helpers.
// Consumed by line_clear_ctrl and line_score_acc.
package tetris_pkg;

  localparam int DEF_BOARD_W  = 12;
  localparam int DEF_BOARD_H  = 19;
  localparam int DEF_ROW_BITS = 16;
  localparam int ROW_ADDR_W   = 5;
  localparam int SCORE_W      = 16;
  localparam int COUNT_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT,
    CLEAR_TOP,
    DONE
  } lc_state_t;

  localparam logic [SCORE_W-1:0] SCORE_NONE   = 16'd0;
  localparam logic [SCORE_W-1:0] SCORE_SINGLE = 16'd40;
  localparam logic [SCORE_W-1:0] SCORE_DOUBLE = 16'd100;
  localparam logic [SCORE_W-1:0] SCORE_TRIPLE = 16'd300;
  localparam logic [SCORE_W-1:0] SCORE_TETRIS = 16'd1200;

  // Only the low 'width' columns are playable; bits above are don't-care.
  function automatic logic row_full(input logic [DEF_ROW_BITS-1:0] row,
                                    input int width);
    logic full;
    full = 1'b1;
    for (int i = 0; i < DEF_ROW_BITS; i++) begin
      if ((i < width) && !row[i]) begin
        full = 1'b0;
      end
    end
    return full;
  endfunction

  function automatic logic [SCORE_W-1:0] score_for(input logic [COUNT_W-1:0] lines);
    logic [SCORE_W-1:0] pts;
    case (lines)
      3'd0:    pts = SCORE_NONE;
      3'd1:    pts = SCORE_SINGLE;
      3'd2:    pts = SCORE_DOUBLE;
      3'd3:    pts = SCORE_TRIPLE;
      default: pts = SCORE_TETRIS;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/line_score_acc.sv
// Saturating score accumulator: adds i_add_val on i_add_en, sticks at all-ones.
// Result visible the cycle after the add; cleared by synchronous Reset.
module line_score_acc
  import tetris_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               i_add_en,
  input  logic [SCORE_W-1:0] i_add_val,
  output logic [SCORE_W-1:0] o_total
);

  logic [SCORE_W-1:0] r_total;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_sat;

  assign w_sum = {1'b0, r_total} + {1'b0, i_add_val};
  assign w_sat = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_total <= '0;
    end else if (i_add_en) begin
      r_total <= w_sat;
    end
  end

  assign o_total = r_total;

endmodule

// File: rtl/line_clear_ctrl.sv
// Post-lock line-clear sequencer: scans rows bottom-up, collapses full rows, reports count.
// Score accumulation only when LINE_CLEAR_SCORE_EN is defined; otherwise score_total is 0.
module line_clear_ctrl
  import tetris_pkg::*;
#(
  parameter int BOARD_W  = DEF_BOARD_W,
  parameter int BOARD_H  = DEF_BOARD_H,
  parameter int ROW_BITS = DEF_ROW_BITS
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  lock,
  output logic [ROW_ADDR_W-1:0] rd_row,
  input  logic [ROW_BITS-1:0]   rd_data,
  output logic                  wr_en,
  output logic [ROW_ADDR_W-1:0] wr_row,
  output logic [ROW_BITS-1:0]   wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [COUNT_W-1:0]    lines_cleared,
  output logic [SCORE_W-1:0]    score_total
);

  localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(BOARD_H - 1);

  lc_state_t             r_state;
  lc_state_t             w_next_state;
  logic [ROW_ADDR_W-1:0] r_scan_row;
  logic [ROW_ADDR_W-1:0] r_dst;
  logic [COUNT_W-1:0]    r_count;
  logic [COUNT_W-1:0]    r_lines;
  logic                  w_row_full;
  logic                  w_scan_top;
  logic [COUNT_W-1:0]    w_count_inc;

  assign w_row_full  = row_full(rd_data, BOARD_W);
  assign w_scan_top  = (r_scan_row == '0);
  assign w_count_inc = (r_count == 3'd7) ? 3'd7 : r_count + 3'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A full row 0 has nothing above it to copy, so it goes straight to CLEAR_TOP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (lock) begin
          w_next_state = SCAN;
        end
      end
      SCAN: begin
        if (w_row_full) begin
          w_next_state = w_scan_top ? CLEAR_TOP : SHIFT;
        end else if (w_scan_top) begin
          w_next_state = DONE;
        end
      end
      SHIFT: begin
        if (r_dst == ROW_ADDR_W'(1)) begin
          w_next_state = CLEAR_TOP;
        end
      end
      CLEAR_TOP: w_next_state = SCAN;
      DONE:      w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_row  = '0;
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      SCAN: begin
        busy   = 1'b1;
        rd_row = r_scan_row;
      end
      SHIFT: begin
        busy    = 1'b1;
        rd_row  = r_dst - ROW_ADDR_W'(1);
        wr_en   = 1'b1;
        wr_row  = r_dst;
        wr_data = rd_data;
      end
      CLEAR_TOP: begin
        busy  = 1'b1;
        wr_en = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // scan_row is held across a collapse so the row pulled down gets rescanned.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_scan_row <= '0;
      r_dst      <= '0;
      r_count    <= '0;
      r_lines    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (lock) begin
            r_scan_row <= LAST_ROW;
            r_count    <= '0;
          end
        end
        SCAN: begin
          if (w_row_full) begin
            r_count <= w_count_inc;
            r_dst   <= r_scan_row;
          end else if (!w_scan_top) begin
            r_scan_row <= r_scan_row - ROW_ADDR_W'(1);
          end
        end
        SHIFT:   r_dst   <= r_dst - ROW_ADDR_W'(1);
        DONE:    r_lines <= r_count;
        default: ;
      endcase
    end
  end

  assign lines_cleared = r_lines;

`ifdef LINE_CLEAR_SCORE_EN
  logic               w_score_en;
  logic [SCORE_W-1:0] w_score_add;

  assign w_score_en  = (r_state == DONE);
  assign w_score_add = score_for(r_count);

  line_score_acc u_score_acc (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_add_en  (w_score_en),
    .i_add_val (w_score_add),
    .o_total   (score_total)
  );
`else
  assign score_total = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl: table of board images plus reset/lock/saturation sequences.
module tb_line_clear_ctrl;
  import tetris_pkg::*;

`ifdef LINE_CLEAR_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  localparam int H = 19;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        lock;
  logic [4:0]  rd_row;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_row;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic [2:0]  lines_cleared;
  logic [15:0] score_total;

  logic [15:0] mem [H];
  logic [15:0] img [H];
  logic        ld;
  int          wcnt;

  int nvec  = 0;
  int nfail = 0;
  int exp_score = 0;

  always #5 Clk = ~Clk;

  line_clear_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .lock          (lock),
    .rd_row        (rd_row),
    .rd_data       (rd_data),
    .wr_en         (wr_en),
    .wr_row        (wr_row),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .score_total   (score_total)
  );

  // Board store: combinational read, registered write; ld loads a whole image.
  assign rd_data = (rd_row < 5'(H)) ? mem[rd_row] : 16'h0000;

  always @(posedge Clk) begin
    if (ld) begin
      for (int i = 0; i < H; i++) mem[i] <= img[i];
      wcnt <= 0;
    end else if (wr_en) begin
      if (wr_row < 5'(H)) mem[wr_row] <= wr_data;
      wcnt <= wcnt + 1;
    end
  end

  typedef struct {
    string       name;
    logic [18:0] full_mask;
    logic [15:0] full_val;
    int          pr_row;
    logic [15:0] pr_val;
    int          exp_busy;
    int          exp_lines;
    int          exp_add;
    int          exp_writes;
    int          chk_row;
    logic [15:0] chk_val;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 65535) ? 65535 : a + b;
  endfunction

  task automatic preload(input logic [18:0] mask, input logic [15:0] fv,
                         input int pr_row, input logic [15:0] pr_val);
    for (int i = 0; i < H; i++) img[i] = mask[i] ? fv : 16'h0000;
    if (pr_row >= 0) img[pr_row] = pr_val;
    @(negedge Clk); ld = 1'b1;
    @(negedge Clk); ld = 1'b0;
  endtask

  // Pulses lock, counts busy cycles (bounded), then checks done, count, score, writes.
  task automatic run_lock(input string nm, input int exp_busy, input int exp_lines,
                          input int exp_add, input int exp_writes, input int mid_lock_at);
    int n;
    n = 0;
    @(negedge Clk); lock = 1'b1;
    @(negedge Clk); lock = 1'b0;
    while (busy && n < 400) begin
      n++;
      lock = (n == mid_lock_at);
      @(negedge Clk);
    end
    lock = 1'b0;
    exp_score = SCORE_EN ? sat_add(exp_score, exp_add) : 0;
    check({nm, " busy_cycles"}, n, exp_busy);
    check({nm, " done_pulse"}, int'(done), 1);
    @(negedge Clk);
    check({nm, " done_width"}, int'(done), 0);
    check({nm, " lines"}, int'(lines_cleared), exp_lines);
    check({nm, " score"}, int'(score_total), exp_score);
    check({nm, " writes"}, wcnt, exp_writes);
  endtask

  initial begin
    vecs[0] = '{"empty",       19'h00000, 16'h0FFF, -1, 16'h0000,  19, 0,    0,   0,  0, 16'h0000};
    vecs[1] = '{"row18",       19'h40000, 16'h0FFF, 17, 16'h000F,  39, 1,   40,  19, 18, 16'h000F};
    vecs[2] = '{"tetris",      19'h78000, 16'h0FFF, 14, 16'h0123,  99, 4, 1200,  76, 18, 16'h0123};
    vecs[3] = '{"row0",        19'h00001, 16'hFFFF, -1, 16'h0000,  21, 1,   40,   1,  0, 16'h0000};
    vecs[4] = '{"row5_hibits", 19'h00020, 16'hFFFF,  4, 16'hF7FF,  26, 1,   40,   6,  5, 16'hF7FF};
    vecs[5] = '{"rows0_18",    19'h40001, 16'h0FFF, 17, 16'h0555,  42, 2,  100,  21, 18, 16'h0555};
    vecs[6] = '{"eight_sat7",  19'h7F800, 16'h0FFF, 10, 16'h0AAA, 179, 7, 1200, 152, 18, 16'h0AAA};

    Reset = 1'b1;
    lock  = 1'b0;
    ld    = 1'b0;
    for (int i = 0; i < H; i++) img[i] = 16'h0000;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("rst busy",  int'(busy), 0);
    check("rst done",  int'(done), 0);
    check("rst wr_en", int'(wr_en), 0);
    check("rst wr_row", int'(wr_row), 0);
    check("rst wr_data", int'(wr_data), 0);
    check("rst rd_row", int'(rd_row), 0);
    check("rst lines", int'(lines_cleared), 0);
    check("rst score", int'(score_total), 0);

    for (int v = 0; v < 7; v++) begin
      preload(vecs[v].full_mask, vecs[v].full_val, vecs[v].pr_row, vecs[v].pr_val);
      run_lock(vecs[v].name, vecs[v].exp_busy, vecs[v].exp_lines, vecs[v].exp_add,
               vecs[v].exp_writes, -1);
      check({vecs[v].name, " row_after"}, int'(mem[vecs[v].chk_row]), int'(vecs[v].chk_val));
    end
    check("tetris row15 old11", int'(mem[15]), 0);
    check("row18 top cleared", int'(mem[0]), 0);

    // Second lock while busy must neither extend nor restart the sequence.
    preload(19'h00000, 16'h0000, -1, 16'h0000);
    run_lock("midlock", 19, 0, 0, 0, 5);
    for (int k = 0; k < 3; k++) begin
      check("midlock stays idle", int'(busy), 0);
      @(negedge Clk);
    end

    // Reset while shifting: idle next cycle, counters cleared, board left partial.
    preload(19'h40000, 16'h0FFF, 17, 16'h000F);
    @(negedge Clk); lock = 1'b1;
    @(negedge Clk); lock = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("rst_mid busy before", int'(busy), 1);
    check("rst_mid wr_en before", int'(wr_en), 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    exp_score = 0;
    check("rst_mid busy", int'(busy), 0);
    check("rst_mid wr_en", int'(wr_en), 0);
    check("rst_mid score", int'(score_total), 0);
    check("rst_mid lines", int'(lines_cleared), 0);
    begin
      int w0;
      w0 = wcnt;
      repeat (6) @(negedge Clk);
      check("rst_mid no writes", wcnt, w0);
      check("rst_mid still idle", int'(busy), 0);
      check("rst_mid row18 partial", int'(mem[18]), 16'h000F);
    end

    // Repeated tetrises drive the accumulator past 16'hFFFF.
    for (int t = 0; t < 55; t++) begin
      preload(19'h78000, 16'h0FFF, 14, 16'h0123);
      run_lock("sat_tetris", 99, 4, 1200, 76, -1);
    end
    check("score saturated", int'(score_total), SCORE_EN ? 65535 : 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/line_clear_ctrl.md
# line_clear_ctrl

Sequences the post-lock phase of a Tetris turn. After the game logic locks a falling piece into the board, this block scans the board rows bottom to top and collapses every full row by copying the rows above it down. It then reports the number of lines cleared and optionally keeps a running score. It is the sole writer of the row-wide board store while busy; game logic must stall new-piece spawn until `done`.

## Interface
- `BOARD_W`, 12: playable columns; row bits `[BOARD_W-1:0]` are used, the rest are ignored.
- `BOARD_H`, 19: rows. Row 0 is the top; row `BOARD_H-1` is the bottom.
- `ROW_BITS`, 16: width of a board row word.

Ports:
- `Clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `lock` in 1: one-cycle pulse; the piece has been written into the board.
- `rd_row` out 5: board row read address.
- `rd_data` in `ROW_BITS`: combinational read data for `rd_row`, valid in the same cycle.
- `wr_en` out 1: board row write strobe.
- `wr_row` out 5: board row write address.
- `wr_data` out `ROW_BITS`: board row write data.
- `busy` out 1: sequencing in progress.
- `done` out 1: one-cycle completion pulse.
- `lines_cleared` out 3: lines cleared by the last sequence; held until the next `lock`.
- `score_total` out 16: accumulated score.

## Operation
- Full row: `rd_data[BOARD_W-1:0]` is all ones.
- **IDLE**
  - `busy`=0.
  - On `lock`: `scan_row`←`BOARD_H-1`, `count`←0, go to SCAN.
- **SCAN**
  - `rd_row`=`scan_row`.
  - Full row: `count`←sat7(`count`+1), `dst`←`scan_row`, go to SHIFT.
  - Not full and `scan_row`==0: go to DONE.
  - Otherwise: `scan_row`−1.
- **SHIFT**
  - `rd_row`=`dst`−1, `wr_en`=1, `wr_row`=`dst`, `wr_data`=`rd_data`.
  - `dst`−1 each cycle.
  - After the write to row 1, go to CLEAR_TOP.
- **CLEAR_TOP**
  - `wr_en`=1, `wr_row`=0, `wr_data`=0.
  - Return to SCAN with `scan_row` unchanged, so the shifted-in row is rescanned.
- **DONE**
  - `done`=1, `busy`=0.
  - `lines_cleared`←`count`.
  - Score update (if enabled).
  - Go to IDLE.
- `lock` while not in IDLE is ignored. Game logic is responsible for not locking while `busy`.
- `count` saturates at 7.
- A full row 0 is detected, then handled by CLEAR_TOP directly with zero SHIFT cycles, then rescanned (now empty).
- When not writing, `wr_en`=0 and `wr_row`/`wr_data` are 0.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `done`, `wr_en`, `wr_row`, `wr_data`, `rd_row`, `lines_cleared`, `score_total` all 0.
- `lock` sampled at edge k: `busy`=1 from cycle k+1.
- With no full rows: `busy` lasts `BOARD_H` cycles, then `done` for exactly one cycle.
- Each row cleared while detected at index r adds r+2 busy cycles. Total busy = `BOARD_H` + Σ(rᵢ+2).
- `lines_cleared` and `score_total` update on the edge that leaves DONE. They are visible the cycle after `done`.
- Reset mid-sequence:
  - Returns to IDLE next cycle.
  - No further writes.
  - `count` and `score_total` are cleared.
  - A partially shifted board is left as-is.

## Configuration
- `LINE_CLEAR_SCORE_EN` defined:
  - DONE adds the table value for `count`: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - The add saturates at 16'hFFFF.
- Not defined: `score_total` is tied to 0 and no accumulator is inferred.

## Structure
- Package `tetris_pkg` holds:
  - `BOARD_W`/`BOARD_H` defaults.
  - the `lc_state_t` enum (IDLE, SCAN, SHIFT, CLEAR_TOP, DONE).
  - the score table constants.
  - the `row_full(row, width)` function.
- One sub-module, `line_score_acc`: the saturating score accumulator, instantiated only under `LINE_CLEAR_SCORE_EN`.

## Test plan
- Empty board, `lock` → `busy` for 19 cycles, `done` on cycle 20, `lines_cleared`=0, no `wr_en`.
- Row 18 full, row 17=12'h00F → 39 busy cycles, row 18 becomes 12'h00F, row 0 becomes 0, `lines_cleared`=1, `score_total`=40.
- Rows 15–18 full → `lines_cleared`=4, `score_total`=1200, rows 15–18 become the old rows 11–14.
- Row 0 only full → one CLEAR_TOP write to row 0 with 0, `lines_cleared`=1, busy = 19+2 = 21.
- `Reset` asserted during SHIFT → next cycle IDLE, `wr_en`=0, `score_total`=0; a second `lock` mid-busy has no effect.
- `score_total` preloaded near 16'hFFF0 via repeated tetrises → saturates at 16'hFFFF.
